// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags with a single head checkpoint
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   dispatch_en         - consume the head tag this cycle
//   free, t_out         - list non-empty; head tag
//   retire_en,
//   retire_t_old        - recycle a retired tag (pushed only when its valid bit is set)
//   checkpoint_en       - save the post-pop head pointer for a new branch
//   rollback_en         - restore head from the checkpoint (pop/checkpoint ignored)
//   count               - number of free tags
//   overflow_err        - sticky: a push was attempted while full
// Tag layout on t_out / retire_t_old: {phys_reg, valid}, valid in bit 0.
module free_list #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32,
    parameter int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ,
    localparam int RW = $clog2(PHYS_REG_SZ),
    localparam int PW = $clog2(FL_SZ) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          dispatch_en,
    output logic          free,
    output logic [RW:0]   t_out,
    input  logic          retire_en,
    input  logic [RW:0]   retire_t_old,
    input  logic          checkpoint_en,
    input  logic          rollback_en,
    output logic [PW-1:0] count,
    output logic          overflow_err
);
    logic [RW-1:0] entry [FL_SZ];
    logic [PW-1:0] head, tail, ckpt, head_nxt;
    logic full, pop, push_try, push;

    // Pointers carry a wrap bit, so tail - head is the occupancy even when
    // the indices are equal (empty vs. full differ only in the wrap bit).
    always_comb begin
        count    = tail - head;
        free     = count != '0;
        full     = count == PW'(FL_SZ);
        t_out    = {entry[head[PW-2:0]], free};
        pop      = dispatch_en && free && !rollback_en;
        push_try = retire_en && retire_t_old[0];
        push     = push_try && !full;
        head_nxt = rollback_en ? ckpt : head + PW'(pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SZ; i++) entry[i] <= RW'(ARCH_REG_SZ + i);
            head         <= '0;
            ckpt         <= '0;
            tail         <= PW'(FL_SZ);
            overflow_err <= 1'b0;
        end else begin
            if (push) entry[tail[PW-2:0]] <= retire_t_old[RW:1];
            if (push) tail <= tail + 1'b1;
            head <= head_nxt;
            // Checkpoint the post-pop head so the branch keeps its own tag.
            if (checkpoint_en && !rollback_en) ckpt <= head_nxt;
            if (push_try && full) overflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed + randomized bench for free_list against a queue-based model
module tb_free_list;
    localparam int RW = 6;
    localparam int FLS = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dispatch_en = 1'b0;
    logic          free;
    logic [RW:0]   t_out;
    logic          retire_en = 1'b0;
    logic [RW:0]   retire_t_old = '0;
    logic          checkpoint_en = 1'b0;
    logic          rollback_en = 1'b0;
    logic [5:0]    count;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;

    // Model: fl holds free tags head-first; hist holds tags popped since the
    // checkpoint, which a rollback puts back in front of the list.
    int fl[$];
    int hist[$];
    bit ovf;

    free_list dut (
        .clock(clock), .reset(reset), .dispatch_en(dispatch_en), .free(free),
        .t_out(t_out), .retire_en(retire_en), .retire_t_old(retire_t_old),
        .checkpoint_en(checkpoint_en), .rollback_en(rollback_en),
        .count(count), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", n, got, exp);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), fl.size());
        chk("free", 32'(free), 32'(fl.size() != 0));
        chk("valid", 32'(t_out[0]), 32'(fl.size() != 0));
        if (fl.size() > 0) chk("tag", 32'(t_out[RW:1]), fl[0]);
        chk("ovf", 32'(overflow_err), 32'(ovf));
    endtask

    task automatic model_reset();
        fl.delete();
        hist.delete();
        for (int i = 0; i < FLS; i++) fl.push_back(32 + i);
        ovf = 1'b0;
    endtask

    // Assert reset between edges, check outputs right away, release on a negedge.
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b0;
        dispatch_en = 1'b0; retire_en = 1'b0; retire_t_old = '0;
        checkpoint_en = 1'b0; rollback_en = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32);
        chk("rst_free", 32'(free), 1);
        chk("rst_tout", 32'(t_out), {25'd0, 6'd32, 1'b1});
        chk("rst_ovf", 32'(overflow_err), 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic cyc(input bit d, input bit r, input int tag, input bit v,
                       input bit c, input bit rb);
        int sz;
        bit full;
        logic [5:0] t6;
        @(negedge clock);
        t6 = tag[5:0];
        dispatch_en = d; retire_en = r; retire_t_old = {t6, v};
        checkpoint_en = c; rollback_en = rb;
        #1 check_model();
        @(posedge clock);
        sz = fl.size();
        full = (sz == FLS);
        if (rb) begin
            fl = {hist, fl};
            hist.delete();
        end else begin
            if (d && sz > 0) hist.push_back(fl.pop_front());
            if (c) hist.delete();
        end
        if (r && v) begin
            if (full) ovf = 1'b1;
            else fl.push_back(tag);
        end
    endtask

    initial begin
        model_reset();
        do_reset();

        // Drain all 32 tags in order.
        for (int i = 0; i < FLS; i++) cyc(1, 0, 0, 0, 0, 0);
        #2;
        chk("drain_count", 32'(count), 0);
        chk("drain_free", 32'(free), 0);
        chk("drain_valid", 32'(t_out[0]), 0);

        // Empty: pop ignored, push of 40 lands.
        cyc(1, 1, 40, 1, 0, 0);
        #2;
        chk("empty_push_count", 32'(count), 1);
        chk("empty_push_tag", 32'(t_out[RW:1]), 40);
        cyc(0, 0, 0, 0, 0, 0);

        // Full: push overflows, invalid push does nothing.
        do_reset();
        cyc(0, 1, 5, 1, 0, 0);
        #2;
        chk("ovf_set", 32'(overflow_err), 1);
        chk("ovf_count", 32'(count), 32);
        cyc(0, 1, 9, 0, 0, 0);
        #2;
        chk("inv_count", 32'(count), 32);
        chk("inv_tag", 32'(t_out[RW:1]), 32);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Checkpoint on the 2nd pop, rollback with pop + push of 7.
        do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 1, 0, 1);
        #2;
        chk("rb_tag", 32'(t_out[RW:1]), 34);
        chk("rb_count", 32'(count), 31);
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 0, 0, 0);
        #2;
        chk("rb_tail_tag", 32'(t_out[RW:1]), 7);
        chk("rb_tail_count", 32'(count), 1);

        // Random streaming with an asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit d, r, c, rb, v;
            int t;
            if (i == 150) do_reset();
            d  = $urandom_range(0, 9) < 6;
            r  = ($urandom_range(0, 9) < 5) && (fl.size() + hist.size() < FLS);
            v  = $urandom_range(0, 7) != 0;
            c  = $urandom_range(0, 9) == 0;
            rb = $urandom_range(0, 19) == 0;
            t  = int'($urandom_range(0, 63));
            cyc(d, r, t, v, c, rb);
        end
        cyc(0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
